// File: rtl/mem_stage_if.sv
// M-stage bus bundle: X->M operands, data-memory request/ack channel and M->W register outputs.
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic              m_valid;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [CTRL_W-1:0] m_wctrl;
    logic              stall;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    logic              w_valid;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_err;

    modport slave (
        input  m_valid, m_read, m_write, m_addr, m_wdata, m_wctrl,
        input  dmem_ack, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output w_valid, w_ctrl, w_alu, w_rdata, w_err
    );

    modport master (
        output m_valid, m_read, m_write, m_addr, m_wdata, m_wctrl,
        output dmem_ack, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  w_valid, w_ctrl, w_alu, w_rdata, w_err
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: single-outstanding load/store on the dmem bus, stalls upstream while waiting.
// Optional watchdog that aborts a hung access with w_err=10: define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  io_bus
);
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_w_valid;
    logic [CTRL_W-1:0] r_w_ctrl;
    logic [DATA_W-1:0] r_w_alu;
    logic [DATA_W-1:0] r_w_rdata;
    logic [1:0]        r_w_err;

    logic              w_stall;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [DATA_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_wv_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [1:0]        w_err_nxt;

    logic              w_mem_op;
    logic              w_misaligned;
    logic              w_timeout;

    assign w_mem_op     = io_bus.m_valid & (io_bus.m_read | io_bus.m_write);
    assign w_misaligned = |io_bus.m_addr[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Counts unacknowledged WAIT cycles; held at zero whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (!io_bus.dmem_ack) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stall and next values for the request and M->W registers.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_req_nxt   = r_dmem_req;
        w_we_nxt    = r_dmem_we;
        w_addr_nxt  = r_dmem_addr;
        w_wdata_nxt = r_dmem_wdata;
        w_wv_nxt    = 1'b0;
        w_rdata_nxt = '0;
        w_err_nxt   = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                w_req_nxt = 1'b0;
                if (w_mem_op && !w_misaligned) begin
                    w_stall     = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = io_bus.m_write;
                    w_addr_nxt  = io_bus.m_addr;
                    w_wdata_nxt = io_bus.m_wdata;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_wv_nxt  = io_bus.m_valid;
                    w_err_nxt = w_mem_op ? ERR_MISALIGN : ERR_NONE;
                end
            end
            ST_WAIT: begin
                if (io_bus.dmem_ack) begin
                    w_wv_nxt    = 1'b1;
                    w_rdata_nxt = r_dmem_we ? '0 : io_bus.dmem_rdata;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_wv_nxt    = 1'b1;
                    w_err_nxt   = ERR_TIMEOUT;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Request channel and M->W pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_w_valid    <= 1'b0;
            r_w_ctrl     <= '0;
            r_w_alu      <= '0;
            r_w_rdata    <= '0;
            r_w_err      <= ERR_NONE;
        end else begin
            r_dmem_req   <= w_req_nxt;
            r_dmem_we    <= w_we_nxt;
            r_dmem_addr  <= w_addr_nxt;
            r_dmem_wdata <= w_wdata_nxt;
            r_w_valid    <= w_wv_nxt;
            r_w_ctrl     <= io_bus.m_wctrl;
            r_w_alu      <= io_bus.m_addr;
            r_w_rdata    <= w_rdata_nxt;
            r_w_err      <= w_err_nxt;
        end
    end

    assign io_bus.stall      = w_stall;
    assign io_bus.dmem_req   = r_dmem_req;
    assign io_bus.dmem_we    = r_dmem_we;
    assign io_bus.dmem_addr  = r_dmem_addr;
    assign io_bus.dmem_wdata = r_dmem_wdata;
    assign io_bus.w_valid    = r_w_valid;
    assign io_bus.w_ctrl     = r_w_ctrl;
    assign io_bus.w_alu      = r_w_alu;
    assign io_bus.w_rdata    = r_w_rdata;
    assign io_bus.w_err      = r_w_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level model checked every cycle plus literal expectations.
module tb_mem_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mem_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

    mem_stage #(.DATA_W(DW), .CTRL_W(CW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: one outstanding access, tracked by how long it has waited.
    bit          busy;
    int          waited;
    logic        e_req, e_we, e_wv;
    logic [31:0] e_addr, e_wdata, e_alu, e_rdata;
    logic [7:0]  e_ctrl;
    logic [1:0]  e_err;

    always @(negedge clk) begin
        bit mem_op, aligned, e_stall;
        if (rst) begin
            chk("rst_req", bus.dmem_req, 0);
            chk("rst_wvalid", bus.w_valid, 0);
            chk("rst_err", bus.w_err, 0);
            busy = 0; waited = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_wv = 0; e_alu = 0; e_ctrl = 0; e_rdata = 0; e_err = 0;
        end else begin
            mem_op  = bus.m_valid && (bus.m_read || bus.m_write);
            aligned = (bus.m_addr[1:0] == 2'b00);
            if (!busy) e_stall = mem_op && aligned;
            else       e_stall = !bus.dmem_ack && !(TO_EN && waited == int'(TO) - 1);
            chk("stall", bus.stall, e_stall);
            if (bus.stall === 1'b1) stall_cnt++;
            chk("dmem_req", bus.dmem_req, e_req);
            if (e_req) begin
                chk("dmem_we", bus.dmem_we, e_we);
                chk("dmem_addr", bus.dmem_addr, e_addr);
                chk("dmem_wdata", bus.dmem_wdata, e_wdata);
            end
            chk("w_valid", bus.w_valid, e_wv);
            chk("w_err", bus.w_err, e_err);
            chk("w_rdata", bus.w_rdata, e_rdata);
            if (e_wv) begin
                chk("w_ctrl", bus.w_ctrl, e_ctrl);
                chk("w_alu", bus.w_alu, e_alu);
            end
            // Outcome of the coming edge.
            e_ctrl = bus.m_wctrl; e_alu = bus.m_addr; e_rdata = 0; e_err = 0;
            if (!busy) begin
                if (mem_op && aligned) begin
                    busy = 1; waited = 0; e_wv = 0;
                    e_req = 1; e_we = bus.m_write; e_addr = bus.m_addr; e_wdata = bus.m_wdata;
                end else begin
                    e_wv  = bus.m_valid;
                    e_err = mem_op ? 2'd1 : 2'd0;
                end
            end else if (bus.dmem_ack) begin
                e_wv = 1; e_rdata = e_we ? 32'd0 : bus.dmem_rdata; e_req = 0; busy = 0;
            end else if (TO_EN && waited == int'(TO) - 1) begin
                e_wv = 1; e_err = 2'd2; e_req = 0; busy = 0;
            end else begin
                e_wv = 0; waited++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_valid = 0; bus.m_read = 0; bus.m_write = 0;
        bus.m_addr = 0; bus.m_wdata = 0; bus.m_wctrl = 0;
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
    endtask

    // Presents an aligned op, acks after ack_dly unacked WAIT cycles, returns just after the ack edge.
    task automatic do_mem(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] ctrl, input int ack_dly, input logic [31:0] rdata);
        bus.m_valid = 1; bus.m_read = rd; bus.m_write = wr;
        bus.m_addr = addr; bus.m_wdata = wdata; bus.m_wctrl = ctrl; bus.dmem_ack = 0;
        step();
        chk("issue_req", bus.dmem_req, 1);
        chk("issue_we", bus.dmem_we, wr);
        chk("issue_addr", bus.dmem_addr, addr);
        if (wr) chk("issue_wdata", bus.dmem_wdata, wdata);
        for (int i = 0; i < ack_dly; i++) step();
        bus.dmem_ack = 1; bus.dmem_rdata = rdata;
        step();
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        bus.m_valid = 0; bus.m_read = 0; bus.m_write = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_dmem_addr", bus.dmem_addr, 0);
        chk("rst_dmem_wdata", bus.dmem_wdata, 0);
        chk("rst_w_ctrl", bus.w_ctrl, 0);
        chk("rst_w_alu", bus.w_alu, 0);
        step();

        // Non-memory op.
        stall_cnt = 0;
        bus.m_valid = 1; bus.m_addr = 32'h1234; bus.m_wctrl = 8'hA5;
        step();
        chk("nonmem_valid", bus.w_valid, 1);
        chk("nonmem_alu", bus.w_alu, 32'h1234);
        chk("nonmem_ctrl", bus.w_ctrl, 8'hA5);
        chk("nonmem_rdata", bus.w_rdata, 0);
        clear_inputs();
        step();
        chk("nonmem_stall_cnt", stall_cnt, 0);

        // Load, ack two cycles after the request rises.
        stall_cnt = 0;
        do_mem(1, 0, 32'h100, 0, 8'h11, 2, 32'hDEADBEEF);
        chk("load_rdata", bus.w_rdata, 32'hDEADBEEF);
        chk("load_valid", bus.w_valid, 1);
        chk("load_err", bus.w_err, 0);
        chk("load_stall_cnt", stall_cnt, 3);

        // Store with immediate ack, back-to-back with a load.
        stall_cnt = 0;
        do_mem(0, 1, 32'h8, 32'h55, 8'h22, 0, 32'hFFFF_FFFF);
        chk("store_stall_cnt", stall_cnt, 1);
        chk("store_gap_req", bus.dmem_req, 0);
        chk("store_rdata", bus.w_rdata, 0);
        chk("store_valid", bus.w_valid, 1);
        do_mem(1, 0, 32'hC, 0, 8'h33, 1, 32'hCAFEF00D);
        chk("b2b_rdata", bus.w_rdata, 32'hCAFEF00D);
        clear_inputs();
        step();

        // Misaligned store and load.
        stall_cnt = 0;
        bus.m_valid = 1; bus.m_write = 1; bus.m_addr = 32'h102; bus.m_wdata = 32'h77;
        #1 chk("mis_stall", bus.stall, 0);
        step();
        chk("mis_err", bus.w_err, 1);
        chk("mis_valid", bus.w_valid, 1);
        chk("mis_req", bus.dmem_req, 0);
        bus.m_write = 0; bus.m_read = 1; bus.m_addr = 32'h3;
        step();
        chk("mis_ld_err", bus.w_err, 1);
        clear_inputs();
        step();
        chk("mis_stall_cnt", stall_cnt, 0);

`ifdef MEM_TIMEOUT_EN
        // Load that is never acked times out after the 4th WAIT cycle.
        bus.m_valid = 1; bus.m_read = 1; bus.m_addr = 32'h40; bus.m_wctrl = 8'h44;
        step();
        repeat (4) step();
        chk("to_err", bus.w_err, 2);
        chk("to_valid", bus.w_valid, 1);
        chk("to_rdata", bus.w_rdata, 0);
        chk("to_req", bus.dmem_req, 0);
        clear_inputs();
        step();
        // Ack in the 4th WAIT cycle wins over the timeout.
        do_mem(1, 0, 32'h44, 0, 8'h45, 3, 32'h0BAD_F00D);
        chk("to_ack_err", bus.w_err, 0);
        chk("to_ack_rdata", bus.w_rdata, 32'h0BAD_F00D);
        clear_inputs();
        step();
`else
        // Long wait: no watchdog, stall persists until the ack.
        stall_cnt = 0;
        do_mem(1, 0, 32'h40, 0, 8'h44, 9, 32'h12345678);
        chk("long_stall_cnt", stall_cnt, 10);
        chk("long_err", bus.w_err, 0);
        chk("long_rdata", bus.w_rdata, 32'h12345678);
        clear_inputs();
        step();
`endif

        // Asynchronous reset mid-WAIT, then a stale ack.
        bus.m_valid = 1; bus.m_read = 1; bus.m_addr = 32'h200;
        step();
        step();
        chk("pre_rst_req", bus.dmem_req, 1);
        #2;
        rst = 1;
        clear_inputs();
        #1;
        chk("async_rst_req", bus.dmem_req, 0);
        chk("async_rst_valid", bus.w_valid, 0);
        chk("async_rst_err", bus.w_err, 0);
        step();
        rst = 0;
        step();
        bus.dmem_ack = 1; bus.dmem_rdata = 32'hBAD0BAD0;
        step();
        bus.dmem_ack = 0; bus.dmem_rdata = 0;
        chk("stale_valid", bus.w_valid, 0);
        chk("stale_rdata", bus.w_rdata, 0);
        chk("stale_req", bus.dmem_req, 0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, between the execute/memory pipeline register and writeback. Takes the load/store operation latched at the X→M boundary and runs it on a single-outstanding data-memory request/acknowledge bus. Holds the upstream pipeline with `stall` while the access is outstanding. Registers the result, the memory/writeback control and any fault into the M→W outputs.

## Interface
Parameters:
- DATA_W, 32, data and address width
- CTRL_W, 8, width of opaque writeback control bundle passed through
- TIMEOUT, 16, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- m_valid  in  1  an instruction is present in M
- m_read  in  1  instruction is a word load
- m_write  in  1  instruction is a word store; never set together with m_read
- m_addr  in  DATA_W  ALU result / effective address
- m_wdata  in  DATA_W  store data, already forwarded
- m_wctrl  in  CTRL_W  writeback control bundle
- stall  out  1  hold upstream registers; combinational
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  DATA_W  registered
- dmem_wdata  out  DATA_W  registered
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack
- w_valid  out  1  M→W register holds an instruction
- w_ctrl  out  CTRL_W  registered m_wctrl
- w_alu  out  DATA_W  registered m_addr
- w_rdata  out  DATA_W  load data; 0 for non-loads and faults
- w_err  out  2  00 none, 01 misaligned, 10 timeout

## Operation
- A memory op is `m_valid & (m_read | m_write)`. It is misaligned when `m_addr[1:0] != 0`.
- FSM states are IDLE and WAIT. Reset state is IDLE.
- **IDLE, no memory op:** the M→W register loads `w_valid=m_valid`, `w_ctrl`, `w_alu`, `w_rdata=0`, `w_err=00`. `stall=0`.
- **IDLE, misaligned memory op:** no request is issued. The M→W register loads with `w_err=01` and `w_rdata=0`. `stall=0`.
- **IDLE, aligned memory op:**
  - `stall=1`.
  - `dmem_req`, `dmem_we=m_write`, `dmem_addr`, `dmem_wdata` are registered high or valid next cycle.
  - Next state is WAIT.
  - The M→W register loads a bubble (`w_valid=0`).
- **WAIT:** `dmem_req` and the request fields are held constant. The upstream stage holds the `m_*` inputs stable while `stall=1`.
  - `dmem_ack=0`: `stall=1`, bubble into M→W.
  - `dmem_ack=1`: `stall=0`. M→W loads `w_valid=1`, with `w_rdata=dmem_rdata` if read, else 0, and `w_err=00`. `dmem_req` drops next cycle. Next state is IDLE.
- `dmem_ack` is ignored in IDLE, i.e. whenever `dmem_req=0`.

## Timing
- Reset values:
  - state IDLE
  - `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`
  - `w_valid=0`, `w_ctrl=0`, `w_alu=0`, `w_rdata=0`, `w_err=00`
  - watchdog counter 0
- Latency:
  - Non-memory or misaligned op: 1 cycle, no stall.
  - Aligned memory op: minimum 2 cycles. Cycle 0 issues, cycle 1 can ack; `stall` is high for 1 cycle.
  - Each extra memory wait cycle adds one stall cycle.
- `dmem_req` rises the cycle after the op is seen in IDLE. It falls the cycle after the ack.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after the first acks, so `dmem_req` has one low cycle between them.
- Reset asserted mid-access: `dmem_req` drops immediately and state goes to IDLE. A subsequent stale ack is ignored.

## Configuration
- Macro: `MEM_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entering WAIT and increments each WAIT cycle without ack.
  - In the WAIT cycle where the counter equals TIMEOUT-1 and `dmem_ack=0`:
    - `stall=0`
    - M→W loads `w_valid=1`, `w_err=10`, `w_rdata=0`
    - `dmem_req` drops next cycle and state returns to IDLE.
  - An ack in that same cycle takes priority and completes normally.
- **Undefined:** no counter. WAIT persists indefinitely and `w_err=10` is never produced.

## Test plan
- Reset: assert `rst` asynchronously mid-WAIT with `dmem_req=1` → `dmem_req`, `w_valid`, `w_err` read 0 immediately. Ack pulsed one cycle after release → no output change.
- Non-memory op: `m_valid=1`, `m_addr=0x1234` → next edge `w_valid=1`, `w_alu=0x1234`, `w_rdata=0`, `stall` never high.
- Load:
  - Stimulus: `m_read`, `m_addr=0x100`, memory acks 2 cycles after `dmem_req` rises with `rdata=0xDEADBEEF`.
  - Response: `stall` high 3 cycles, `dmem_addr=0x100`, `dmem_we=0`, then `w_rdata=0xDEADBEEF`, `w_valid=1`, `w_err=00`.
- Store with immediate ack, then back-to-back load:
  - Store `addr=0x8`, `wdata=0x55`: `dmem_we=1` with `dmem_wdata=0x55`, `stall` exactly 1 cycle.
  - Load that follows: issues after one `dmem_req`-low cycle.
- Misaligned: `m_write`, `m_addr=0x102` → `dmem_req` stays 0, `stall=0`, next edge `w_err=01`, `w_valid=1`.
- Timeout (`MEM_TIMEOUT_EN`, TIMEOUT=4): load with no ack → `w_err=10` after the 4th WAIT cycle, `dmem_req` low next cycle.
- Timeout, ack in the 4th WAIT cycle → normal completion with `w_err=00`.
